// File: rtl/tow_pkg.sv
// Shared tug-of-war definitions: round FSM states and the scorer's terminal patterns.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tow_pkg;

   typedef enum logic [2:0] {
      ST_RELEASE  = 3'd0,
      ST_ARM      = 3'd1,
      ST_LIT      = 3'd2,
      ST_FIRE     = 3'd3,
      ST_HOLD     = 3'd4,
      ST_GAMEOVER = 3'd5
   } state_t;

   // Score word is [L3 L2 L1 N R1 R2 R3]
   localparam logic [6:0] SCORE_WL  = 7'b1110000;
   localparam logic [6:0] SCORE_WR  = 7'b0000111;
   localparam logic [6:0] SCORE_ERR = 7'b1010101;

   // True when the score word ends the game (either player won, or the scorer flagged an error)
   function automatic logic is_final(input logic [6:0] s);
      return (s == SCORE_WL) || (s == SCORE_WR) || (s == SCORE_ERR);
   endfunction

endpackage

// File: rtl/push_sync.sv
// Push button synchronizer (2 flops) plus rising-edge detector on the synchronized level.
// Latency: level valid 2 cycles after the pin is sampled; rise pulses for one cycle in that same cycle.
// Backpressure: none; samples the pin every cycle, a held button yields a single rise.
module push_sync (
   input  logic clk,
   input  logic rst,
   input  logic pb,
   output logic sync,
   output logic rise
);

   logic s1, s2, s3;

   // Metastability chain plus one extra stage to remember the previous level
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= pb;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sync = s2;
   assign rise = s2 & ~s3;

endmodule

// File: rtl/round_ctrl.sv
// Tug-of-war round controller: release wait, random lights-off delay, push arbitration, hold, game over.
// Latency: pin sampled high at edge k gives the winrnd pulse in the cycle after edge k+3.
// Backpressure: none; the scorer must accept winrnd whenever it pulses, score is read only at the end of HOLD.
module round_ctrl
   import tow_pkg::*;
#(
   parameter logic [15:0] DELAY_MIN   = 16'd5000,
   parameter int          DELAY_W     = 12,
   parameter logic [15:0] HOLD_CYCLES = 16'd20000,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pb_l,
   input  logic       pb_r,
   input  logic [6:0] score,
   output logic       leds_on,
   output logic       winrnd,
   output logic       right,
   output logic       tie,
   output logic       game_over
);

   logic        s2_l, s2_r, e_l, e_r;
   logic [15:0] lfsr;
   state_t      state, state_nx;
   logic [16:0] cnt, cnt_nx;
   logic        el_q, er_q, lit_q;
   logic        el_nx, er_nx, lit_nx;
   logic        leds_nx, winrnd_nx, right_nx, tie_nx, go_nx;
   logic [16:0] arm_delay, cnt_dec;
   logic        cnt_last;

   push_sync u_sync_l (.clk(clk), .rst(rst), .pb(pb_l), .sync(s2_l), .rise(e_l));
   push_sync u_sync_r (.clk(clk), .rst(rst), .pb(pb_r), .sync(s2_r), .rise(e_r));

   // Free-running Fibonacci LFSR, taps 16,14,13,11
   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign arm_delay = {1'b0, DELAY_MIN} + 17'(lfsr[DELAY_W-1:0]);
   assign cnt_dec   = (cnt != 17'd0) ? cnt - 17'd1 : 17'd0;
   // Leaving on the count-to-1 cycle makes the dwell exactly the loaded value
   assign cnt_last  = (cnt <= 17'd1);

   // Next state, counter loads and push latches; output values derived from them
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      el_nx    = el_q;
      er_nx    = er_q;
      lit_nx   = lit_q;
      case (state)
         ST_RELEASE: begin
            if (!s2_l && !s2_r) begin
               state_nx = ST_ARM;
               cnt_nx   = arm_delay;
            end
         end
         ST_ARM: begin
            cnt_nx = cnt_dec;
            // A push wins over the delay expiring in the same cycle: it is a jump
            if (e_l || e_r) begin
               state_nx = ST_FIRE;
               el_nx    = e_l;
               er_nx    = e_r;
               lit_nx   = 1'b0;
            end else if (cnt_last) begin
               state_nx = ST_LIT;
            end
         end
         ST_LIT: begin
            if (e_l || e_r) begin
               state_nx = ST_FIRE;
               el_nx    = e_l;
               er_nx    = e_r;
               lit_nx   = 1'b1;
            end
         end
         ST_FIRE: begin
            state_nx = ST_HOLD;
            cnt_nx   = {1'b0, HOLD_CYCLES};
         end
         ST_HOLD: begin
            cnt_nx = cnt_dec;
            if (cnt_last) state_nx = is_final(score) ? ST_GAMEOVER : ST_RELEASE;
         end
         ST_GAMEOVER: state_nx = ST_GAMEOVER;
         default:     state_nx = ST_RELEASE;
      endcase

      winrnd_nx = (state == ST_FIRE);
      right_nx  = (state == ST_FIRE) & er_q & ~el_q;
      tie_nx    = (state == ST_FIRE) & er_q & el_q;
      // Lights stay as they were at detection until the winrnd cycle has been shown
      leds_nx   = (state_nx == ST_LIT) | ((state_nx == ST_FIRE) & lit_nx) | ((state == ST_FIRE) & lit_q);
      go_nx     = (state_nx == ST_GAMEOVER);
   end

   // State register, shared counter, push latches and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RELEASE;
         cnt       <= '0;
         el_q      <= 1'b0;
         er_q      <= 1'b0;
         lit_q     <= 1'b0;
         leds_on   <= 1'b0;
         winrnd    <= 1'b0;
         right     <= 1'b0;
         tie       <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         el_q      <= el_nx;
         er_q      <= er_nx;
         lit_q     <= lit_nx;
         leds_on   <= leds_nx;
         winrnd    <= winrnd_nx;
         right     <= right_nx;
         tie       <= tie_nx;
         game_over <= go_nx;
      end
   end

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: table of rounds plus hand sequences for stuck button, reset and game over.
// Latency: expected winrnd cycle is tracked per push through a scoreboard queue.
// Backpressure: n/a.
module tb_round_ctrl;

   localparam int          DMIN = 8;
   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst, pb_l, pb_r;
   logic [6:0] score;
   logic       leds_on, winrnd, right, tie, game_over;

   round_ctrl #(
      .DELAY_MIN(16'd8), .DELAY_W(4), .HOLD_CYCLES(16'd4), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .pb_l(pb_l), .pb_r(pb_r), .score(score),
      .leds_on(leds_on), .winrnd(winrnd), .right(right), .tie(tie), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // mode 0: push once lights are on; 1: push off cycles after ARM entry; 2: push seen in last ARM cycle
   typedef struct packed {
      int mode; int off; bit pl; bit pr; bit stuck; bit er; bit et; bit el;
   } vec_t;
   typedef struct packed { bit r; bit t; bit l; int cyc; } exp_t;

   int          cyc = 0;
   logic [15:0] lfsr_m = SEED;
   int          n_checks = 0, n_pass = 0;
   int          arm_cyc, arm_d;
   exp_t        sb[$];
   exp_t        mon_e;
   vec_t        vecs[8];
   logic [6:0]  go_sc[3];

   // Cycle counter and reference LFSR (value at a negedge = value the DUT holds in that cycle)
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) lfsr_m <= SEED;
      else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Scoreboard: every winrnd pulse must match the oldest pending push
   always @(negedge clk) begin
      if (winrnd === 1'b1) begin
         chk("winrnd_expected", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("right", int'(right), int'(mon_e.r));
            chk("tie", int'(tie), int'(mon_e.t));
            chk("leds_at_win", int'(leds_on), int'(mon_e.l));
            chk("win_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Called at the negedge before ARM entry edge `at`
   task automatic set_arm(input int at);
      arm_cyc = at;
      arm_d   = DMIN + int'(lfsr_m[3:0]);
   endtask

   task automatic wait_win(output int w, output int hi);
      int n;
      n = 0; hi = 0; w = -1;
      while (w < 0 && n < 20) begin
         @(negedge clk);
         n++;
         if (leds_on === 1'b1) hi++;
         if (winrnd === 1'b1) w = cyc;
      end
      chk("winrnd_seen", int'(w >= 0), 1);
      if (w < 0) begin
         if (sb.size() > 0) sb.delete(0);
         w = cyc;
      end
   endtask

   task automatic finish_round(input int w, input bit stuck, input logic [6:0] sc, input bit go);
      int c, hi;
      pb_l  = 1'b0;
      if (!stuck) pb_r = 1'b0;
      score = sc;
      if (go) begin
         repeat (3) @(negedge clk);
         chk("game_over_early", int'(game_over), 0);
         @(negedge clk);
         chk("game_over_set", int'(game_over), 1);
         pb_r = 1'b1; repeat (3) @(negedge clk);
         pb_r = 1'b0; pb_l = 1'b1; repeat (3) @(negedge clk);
         pb_l = 1'b0; repeat (2) @(negedge clk);
         pb_l = 1'b1; pb_r = 1'b1; repeat (4) @(negedge clk);
         pb_l = 1'b0; pb_r = 1'b0; repeat (4) @(negedge clk);
         chk("game_over_held", int'(game_over), 1);
         chk("game_over_dark", int'(leds_on), 0);
         rst = 1'b1; score = 7'd0;
         @(negedge clk);
         chk("game_over_cleared", int'(game_over), 0);
         rst = 1'b0;
         set_arm(cyc + 1);
      end else if (stuck) begin
         hi = 0;
         repeat (12) begin
            @(negedge clk);
            if (leds_on === 1'b1) hi++;
         end
         chk("stuck_dark", hi, 0);
         pb_r = 1'b0;
         c = cyc;
         repeat (2) @(negedge clk);
         set_arm(c + 3);
      end else begin
         for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("hold_dark", int'(leds_on), 0);
         end
         chk("no_game_over", int'(game_over), 0);
         set_arm(w + 5);
      end
   endtask

   task automatic run_vec(input vec_t v, input logic [6:0] sc, input bit go);
      int c, w, hi;
      if (v.mode == 0) begin
         wait_until(arm_cyc + arm_d - 1);
         chk("leds_before_delay", int'(leds_on), 0);
         @(negedge clk);
         chk("leds_after_delay", int'(leds_on), 1);
      end else if (v.mode == 1) begin
         wait_until(arm_cyc + v.off - 1);
      end else begin
         wait_until(arm_cyc + arm_d - 3);
      end
      c    = cyc;
      pb_l = v.pl;
      pb_r = v.pr;
      sb.push_back('{r: v.er, t: v.et, l: v.el, cyc: c + 4});
      wait_win(w, hi);
      if (v.mode != 0) chk("dark_until_win", hi, 0);
      finish_round(w, v.stuck, sc, go);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, %0d/%0d so far", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          mode off pl    pr    stuck er    et    el
      vecs[0] = '{0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{1, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      go_sc[0] = 7'b0000111;
      go_sc[1] = 7'b1010101;
      go_sc[2] = 7'b1110000;

      rst = 1'b1; pb_l = 1'b0; pb_r = 1'b0; score = 7'd0;
      repeat (3) @(negedge clk);
      chk("rst_leds", int'(leds_on), 0);
      chk("rst_winrnd", int'(winrnd), 0);
      chk("rst_right", int'(right), 0);
      chk("rst_tie", int'(tie), 0);
      chk("rst_game_over", int'(game_over), 0);
      rst = 1'b0;
      set_arm(cyc + 1);

      for (int i = 0; i < 8; i++)
         run_vec(vecs[i], (i % 2 == 1) ? 7'b0001000 : 7'b0000000, 1'b0);

      // Reset while lit, with a button edge landing on the reset edge only
      wait_until(arm_cyc + arm_d);
      chk("lit_before_rst", int'(leds_on), 1);
      rst = 1'b1; pb_l = 1'b1;
      @(negedge clk);
      chk("midrst_leds", int'(leds_on), 0);
      chk("midrst_winrnd", int'(winrnd), 0);
      chk("midrst_right", int'(right), 0);
      chk("midrst_tie", int'(tie), 0);
      chk("midrst_game_over", int'(game_over), 0);
      rst = 1'b0; pb_l = 1'b0;
      set_arm(cyc + 1);
      run_vec(vecs[0], 7'd0, 1'b0);

      for (int i = 0; i < 3; i++)
         run_vec(vecs[0], go_sc[i], 1'b1);

      run_vec(vecs[2], 7'd0, 1'b0);
      chk("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Round controller for the tug-of-war game, and the producer of every input the scorer consumes. It runs each round: it waits for both buttons to be released, holds the lights off for a pseudo-random interval, then turns the lights on. It then decides who pushed first and emits a one-cycle `winrnd` pulse with `right`, `tie` and `leds_on` valid in that same cycle. It also watches the scorer's `score` word and stops play when the game is won or when `score` shows the error pattern.

## Interface
Parameters:
- `DELAY_MIN`, default 16'd5000: minimum lights-off interval, in clk cycles.
- `DELAY_W`, default 12: number of LFSR bits added to `DELAY_MIN` to form the random part of the delay.
- `HOLD_CYCLES`, default 16'd20000: post-round display time before the next round may arm.
- `LFSR_SEED`, default 16'hACE1: LFSR value after reset. Must be nonzero.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `pb_l`, in, 1: left push button, debounced, asynchronous to clk.
- `pb_r`, in, 1: right push button, debounced, asynchronous to clk.
- `score`, in, 7: scorer output, [L3 L2 L1 N R1 R2 R3].
- `leds_on`, out, 1: "go" lights. Also tells the scorer whether a push was proper.
- `winrnd`, out, 1: one-cycle pulse meaning a push was resolved.
- `right`, out, 1: 1 when the right player pushed first. Valid while `winrnd`=1.
- `tie`, out, 1: both players pushed in the same cycle. Valid while `winrnd`=1.
- `game_over`, out, 1: set while in GAMEOVER.

## Operation
- Each button passes through a 2-flop synchronizer and a rising-edge detector: `e_x = s2 & ~s3`. Only edges count; a held button never re-triggers.
- A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle and is loaded with `LFSR_SEED` on `rst`.
- `cnt` is a 17-bit down-counter shared by ARM and HOLD.
- FSM states and transitions:
  - RELEASE (the reset state): both outputs dark. Go to ARM when `s2_l`=0 and `s2_r`=0. Entering ARM loads `cnt = DELAY_MIN + lfsr[DELAY_W-1:0]`.
  - ARM: `leds_on`=0. When `cnt` reaches 0, go to LIT.
  - ARM early push: any edge in ARM resolves a jump-the-light and goes to FIRE.
  - LIT: `leds_on`=1. Any edge goes to FIRE. LIT has no timeout.
  - FIRE (exactly one cycle): `winrnd`=1.
    - `tie` = `e_l & e_r` as latched on entry.
    - `right` = `e_r & ~e_l`.
    - `leds_on` holds the value it had in the detecting cycle.
    - Next state is HOLD, which loads `cnt = HOLD_CYCLES`.
  - HOLD: `leds_on`=0 and edges are ignored. At `cnt`=0, go to GAMEOVER if `score` is 7'b1110000, 7'b0000111 or 7'b1010101; otherwise go to RELEASE.
  - GAMEOVER: `game_over`=1 and all other outputs are 0. Only `rst` leaves this state.
- `right`, `tie` and `winrnd` are 0 outside FIRE.
- All outputs are registered.

## Timing
- Reset values: `leds_on`=0, `winrnd`=0, `right`=0, `tie`=0, `game_over`=0, FSM=RELEASE, `cnt`=0, sync flops=0, LFSR=`LFSR_SEED`. All take effect on the first clk edge with `rst`=1. Reset mid-round aborts the round and no `winrnd` is issued.
- Push latency: a button first sampled high at edge k produces `winrnd`=1 for the cycle after edge k+3.
- Lights-off interval: exactly `DELAY_MIN + lfsr[DELAY_W-1:0]` cycles from ARM entry to `leds_on` rising.
- Simultaneous events:
  - An edge in the same cycle that ARM `cnt` hits 0 resolves with `leds_on`=0, i.e. a jump.
  - `e_l` and `e_r` in the same cycle produce a tie: `tie`=1, `right`=0.
- `score` is sampled only at the end of HOLD. The scorer updates one cycle after `winrnd`, so `HOLD_CYCLES` ≥ 2 is required.

## Structure
- Shared package `tow_pkg` holds:
  - The FSM state enum.
  - `SCORE_WL`=7'b1110000, `SCORE_WR`=7'b0000111 and `SCORE_ERR`=7'b1010101, also used by the scorer's output logic.
- Sub-module `push_sync` (2-flop synchronizer plus edge detector) is instantiated twice.
- The LFSR stays inline.

## Test plan
Use `DELAY_MIN`=8, `DELAY_W`=4, `HOLD_CYCLES`=4, `LFSR_SEED`=16'hACE1.
- Proper right push: release both buttons, wait for `leds_on`=1, raise `pb_r` → one `winrnd` pulse with `right`=1, `tie`=0, `leds_on`=1, 3 cycles after sampling. Then `leds_on`=0 for 4 cycles, then back to RELEASE.
- Jump left: raise `pb_l` 2 cycles after ARM entry → `winrnd`=1 with `leds_on`=0 and `right`=0. `leds_on` never rises that round.
- Tie: `pb_l` and `pb_r` rise on the same edge during LIT → `winrnd`=1, `tie`=1, `right`=0.
- Stuck button: hold `pb_r`=1 through HOLD → FSM stays in RELEASE and `leds_on` stays 0 until `pb_r` is released. ARM is then entered with the delay computed from the LFSR at that cycle.
- Game over: drive `score`=7'b0000111 while in HOLD → `game_over`=1 after `cnt` expires, and subsequent pushes produce no `winrnd`. Repeat with `score`=7'b1010101.
- Reset mid-LIT: assert `rst` for 1 cycle → on the next edge all outputs are 0 and FSM is RELEASE. A button edge in the same cycle as `rst` produces no `winrnd`.
